// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
//
// Clock-enable generator running entirely on the fast MMCM clock. Each channel
// produces a one-cycle enable strobe (CE) and a square-wave phase flag (PHASE)
// at a runtime-programmable integer divide ratio. It stands in for extra MMCM
// outputs and global buffers when driving slow pixel/camera/VGA logic.
//
// All outputs stay low until the MMCM lock indicator has been continuously
// high for LOCK_WAIT cycles (after a 2-FF synchroniser). A SYNC pulse restarts
// every channel counter together so that all strobes line up.
//
// Ports:
//   CLK_100  in   fast system clock (MMCM output)
//   RST_N    in   asynchronous active-low reset
//   LOCKED   in   MMCM lock, asynchronous; synchronised internally
//   SYNC     in   synchronous pulse; realigns all channels (RUN only)
//   DIV      in   channel i ratio at [i*DIV_W +: DIV_W]; 0 and 1 = every cycle
//   CE       out  per-channel one-cycle enable strobe (registered)
//   PHASE    out  per-channel square wave, high for the first ceil(N/2)
//                 cycles of each period (registered)
//   READY    out  high while the block is in RUN (registered)
//
// There are no valid/ready handshakes on this block: CE is a free-running
// strobe and READY is a level qualifier, both valid on every clock cycle.
// ---------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int LOCK_WAIT = 1024
) (
    input  logic                    CLK_100,
    input  logic                    RST_N,
    input  logic                    LOCKED,
    input  logic                    SYNC,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    output logic [NUM_CH-1:0]       CE,
    output logic [NUM_CH-1:0]       PHASE,
    output logic                    READY
);

    localparam int                 SET_W    = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [SET_W-1:0]   SET_LAST = SET_W'(LOCK_WAIT - 1);
    localparam logic [SET_W-1:0]   SET_ONE  = SET_W'(1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W:0]     HALF_ONE = (DIV_W + 1)'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t             state;
    logic               lock_meta;
    logic               lock_s;
    logic [SET_W-1:0]   settle_cnt;

    // Per-channel counter and the ratio it is currently running with.
    logic [DIV_W-1:0]   cnt       [NUM_CH];
    logic [DIV_W-1:0]   nact      [NUM_CH];
    logic [DIV_W-1:0]   cnt_next  [NUM_CH];
    logic [DIV_W-1:0]   nact_next [NUM_CH];
    logic [DIV_W-1:0]   div_eff   [NUM_CH];
    logic [DIV_W:0]     half      [NUM_CH];
    logic [NUM_CH-1:0]  wrap;
    logic [NUM_CH-1:0]  ce_next;
    logic [NUM_CH-1:0]  phase_next;
    logic               run_next;
    logic               restart;

    // -----------------------------------------------------------------------
    // Lock synchroniser
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= LOCKED;
            lock_s    <= lock_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Whether the block will be in RUN during the next cycle. The outputs are
    // registered from the next-cycle counter values so that CE/PHASE/READY
    // line up with the counter state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        run_next = 1'b0;
        if (lock_s) begin
            if (state == RUN) begin
                run_next = 1'b1;
            end else if (state == SETTLE && settle_cnt == SET_LAST) begin
                run_next = 1'b1;
            end
        end
    end

    // Counters restart whenever we are not running, or are about to leave
    // RUN because lock was lost. Lock loss therefore wins over SYNC and wrap.
    assign restart = (state != RUN) || !lock_s;

    // -----------------------------------------------------------------------
    // Per-channel next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ce_next    = '0;
        phase_next = '0;
        wrap       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i]   = '0;
            cnt_next[i]  = '0;
            nact_next[i] = '0;
            half[i]      = '0;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            // A ratio of 0 is treated like 1 (strobe every cycle).
            div_eff[i] = (DIV[i*DIV_W +: DIV_W] == '0) ? DIV_ONE
                                                      : DIV[i*DIV_W +: DIV_W];
            wrap[i]    = (cnt[i] == nact[i] - DIV_ONE);

            // The ratio is only sampled at a period boundary (restart, SYNC
            // or wrap), so a mid-period DIV change never truncates or
            // stretches the period already in progress.
            if (restart || SYNC || wrap[i]) begin
                cnt_next[i]  = '0;
                nact_next[i] = div_eff[i];
            end else begin
                cnt_next[i]  = cnt[i] + DIV_ONE;
                nact_next[i] = nact[i];
            end

            // ceil(N/2) computed one bit wider so N = 2^DIV_W-1 cannot overflow.
            half[i]       = ({1'b0, nact_next[i]} + HALF_ONE) >> 1;
            ce_next[i]    = (cnt_next[i] == '0);
            phase_next[i] = ({1'b0, cnt_next[i]} < half[i]);
        end
    end

    // -----------------------------------------------------------------------
    // Channel counters
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= '0;
                nact[i] <= DIV_ONE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]  <= cnt_next[i];
                nact[i] <= nact_next[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock qualification FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or negedge RST_N) begin
        if (!RST_N) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            READY      <= 1'b0;
            CE         <= '0;
            PHASE      <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    settle_cnt <= '0;
                    if (lock_s) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SET_LAST) begin
                        state <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + SET_ONE;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                    state      <= WAIT_LOCK;
                    settle_cnt <= '0;
                end
            endcase

            READY <= run_next;
            CE    <= run_next ? ce_next    : '0;
            PHASE <= run_next ? phase_next : '0;
        end
    end

endmodule
